// File: rtl/msdap_ctrl_if.sv
// msdap_ctrl_if: host/datapath-facing bus of the MSDAP sequencing controller.
//   inData/validData/readyForData : word handshake from the host
//   memWrData, rjWrEn/rjAddr, coeffWrEn/coeffAddr, dataWrEn/dataAddr : memory write port
//   computeStart/computeAbort/computeDone : filter datapath control
//   status : 4-bit controller state code
// Modports: master = host/datapath side, slave = controller side.
interface msdap_ctrl_if #(
  parameter int DATA_W   = 16,
  parameter int RJ_AW    = 4,
  parameter int COEFF_AW = 9,
  parameter int DATA_AW  = 8
);
  logic [DATA_W-1:0]   inData;
  logic                validData;
  logic                readyForData;
  logic [DATA_W-1:0]   memWrData;
  logic                rjWrEn;
  logic [RJ_AW-1:0]    rjAddr;
  logic                coeffWrEn;
  logic [COEFF_AW-1:0] coeffAddr;
  logic                dataWrEn;
  logic [DATA_AW-1:0]  dataAddr;
  logic                computeStart;
  logic                computeAbort;
  logic                computeDone;
  logic [3:0]          status;

  modport master (
    output inData, validData, computeDone,
    input  readyForData, memWrData, rjWrEn, rjAddr, coeffWrEn, coeffAddr,
           dataWrEn, dataAddr, computeStart, computeAbort, status
  );

  modport slave (
    input  inData, validData, computeDone,
    output readyForData, memWrData, rjWrEn, rjAddr, coeffWrEn, coeffAddr,
           dataWrEn, dataAddr, computeStart, computeAbort, status
  );
endinterface

// File: rtl/msdap_ctrl.sv
// msdap_ctrl: top-level sequencing FSM of the MSDAP.
//   Loads RJ_COUNT rj words, then COEFF_COUNT coefficient words, then streams samples into a
//   circular data memory, launching one filter computation per written sample. Sleeps after
//   ZERO_LIMIT consecutive zero samples; softReset clears sample history but keeps rj/coeff.
// Ports:
//   clk       : system clock (rising edge)
//   reset     : asynchronous active-low reset
//   softReset : synchronous active-high sample-history clear
//   bus       : handshake, memory write and compute control signals (slave side)
// All bus outputs are registered.
module msdap_ctrl #(
  parameter int DATA_W      = 16,
  parameter int RJ_COUNT    = 16,
  parameter int COEFF_COUNT = 512,
  parameter int DATA_DEPTH  = 256,
  parameter int ZERO_LIMIT  = 800
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          softReset,
  msdap_ctrl_if.slave   bus
);

  localparam int RJ_AW    = $clog2(RJ_COUNT);
  localparam int COEFF_AW = $clog2(COEFF_COUNT);
  localparam int DATA_AW  = $clog2(DATA_DEPTH);
  localparam int ZC_W     = $clog2(ZERO_LIMIT + 1);

  localparam logic [RJ_AW-1:0]    RJ_LAST    = RJ_AW'(RJ_COUNT - 1);
  localparam logic [COEFF_AW-1:0] COEFF_LAST = COEFF_AW'(COEFF_COUNT - 1);
  localparam logic [DATA_AW-1:0]  DATA_LAST  = DATA_AW'(DATA_DEPTH - 1);
  localparam logic [ZC_W-1:0]     ZERO_MAX   = ZC_W'(ZERO_LIMIT);

  typedef enum logic [3:0] {
    INIT       = 4'd0,
    WAIT_RJ    = 4'd1,
    READ_RJ    = 4'd2,
    WAIT_COEFF = 4'd3,
    READ_COEFF = 4'd4,
    WAIT_DATA  = 4'd5,
    WORKING    = 4'd6,
    CLEARING   = 4'd7,
    SLEEPING   = 4'd8
  } state_t;

  state_t              state, stateD;
  logic [RJ_AW-1:0]    rjAddrQ, rjAddrD;
  logic [COEFF_AW-1:0] coeffAddrQ, coeffAddrD;
  logic [DATA_AW-1:0]  dataAddrQ, dataAddrD;
  logic [DATA_W-1:0]   memWrDataQ, memWrDataD;
  logic                rjWrEnQ, rjWrEnD;
  logic                coeffWrEnQ, coeffWrEnD;
  logic                dataWrEnQ, dataWrEnD;
  logic                startQ, startD;
  logic                abortQ, abortD;
  logic                readyQ, readyD;
  logic [ZC_W-1:0]     zeroCnt, zeroD;
  logic                clrBusy, clrBusyD;      // a clear sweep has written at least address 0
  logic                firstSample, firstD;    // next sample goes to address 0

  logic accept;
  logic sampleZero;
  logic takeSample;

  assign accept     = bus.validData && readyQ;
  assign sampleZero = (bus.inData == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= INIT;
      rjAddrQ     <= '0;
      coeffAddrQ  <= '0;
      dataAddrQ   <= '0;
      memWrDataQ  <= '0;
      rjWrEnQ     <= 1'b0;
      coeffWrEnQ  <= 1'b0;
      dataWrEnQ   <= 1'b0;
      startQ      <= 1'b0;
      abortQ      <= 1'b0;
      readyQ      <= 1'b0;
      zeroCnt     <= '0;
      clrBusy     <= 1'b0;
      firstSample <= 1'b0;
    end else begin
      state       <= stateD;
      rjAddrQ     <= rjAddrD;
      coeffAddrQ  <= coeffAddrD;
      dataAddrQ   <= dataAddrD;
      memWrDataQ  <= memWrDataD;
      rjWrEnQ     <= rjWrEnD;
      coeffWrEnQ  <= coeffWrEnD;
      dataWrEnQ   <= dataWrEnD;
      startQ      <= startD;
      abortQ      <= abortD;
      readyQ      <= readyD;
      zeroCnt     <= zeroD;
      clrBusy     <= clrBusyD;
      firstSample <= firstD;
    end
  end

  always_comb begin
    stateD     = state;
    rjAddrD    = rjAddrQ;
    coeffAddrD = coeffAddrQ;
    dataAddrD  = dataAddrQ;
    memWrDataD = memWrDataQ;
    rjWrEnD    = 1'b0;
    coeffWrEnD = 1'b0;
    dataWrEnD  = 1'b0;
    startD     = 1'b0;
    abortD     = 1'b0;
    zeroD      = zeroCnt;
    clrBusyD   = clrBusy;
    firstD     = firstSample;
    takeSample = 1'b0;

    case (state)
      INIT, CLEARING: begin
        memWrDataD = '0;
        dataWrEnD  = 1'b1;
        if (!clrBusy) begin
          dataAddrD = '0;
          clrBusyD  = 1'b1;
        end else if (dataAddrQ == DATA_LAST) begin
          // Sweep complete: the last-address write was already presented this cycle.
          dataWrEnD = 1'b0;
          dataAddrD = '0;
          clrBusyD  = 1'b0;
          firstD    = 1'b1;
          stateD    = (state == INIT) ? WAIT_RJ : WAIT_DATA;
        end else begin
          dataAddrD = dataAddrQ + 1'b1;
        end
      end

      WAIT_RJ: if (accept) begin
        rjWrEnD    = 1'b1;
        rjAddrD    = '0;
        memWrDataD = bus.inData;
        stateD     = READ_RJ;
      end

      READ_RJ: if (accept) begin
        rjWrEnD    = 1'b1;
        rjAddrD    = rjAddrQ + 1'b1;
        memWrDataD = bus.inData;
        if (rjAddrD == RJ_LAST) stateD = WAIT_COEFF;
      end

      WAIT_COEFF: if (accept) begin
        coeffWrEnD = 1'b1;
        coeffAddrD = '0;
        memWrDataD = bus.inData;
        stateD     = READ_COEFF;
      end

      READ_COEFF: if (accept) begin
        coeffWrEnD = 1'b1;
        coeffAddrD = coeffAddrQ + 1'b1;
        memWrDataD = bus.inData;
        if (coeffAddrD == COEFF_LAST) stateD = WAIT_DATA;
      end

      WAIT_DATA: begin
        if (softReset) begin
          stateD = CLEARING;
          zeroD  = '0;
        end else if (accept) begin
          takeSample = 1'b1;
        end
      end

      WORKING: begin
        if (softReset) begin
          stateD = CLEARING;
          abortD = 1'b1;
          zeroD  = '0;
        end else if (bus.computeDone) begin
          stateD = (zeroCnt == ZERO_MAX) ? SLEEPING : WAIT_DATA;
        end
      end

      SLEEPING: begin
        if (softReset) begin
          stateD = CLEARING;
          zeroD  = '0;
        end else if (accept && !sampleZero) begin
          takeSample = 1'b1;
        end
      end

      default: stateD = INIT;
    endcase

    // Shared sample-write path for WAIT_DATA and a waking nonzero sample in SLEEPING.
    if (takeSample) begin
      dataWrEnD  = 1'b1;
      memWrDataD = bus.inData;
      dataAddrD  = firstSample ? '0 : dataAddrQ + 1'b1;
      firstD     = 1'b0;
      startD     = 1'b1;
      stateD     = WORKING;
      if (!sampleZero)              zeroD = '0;
      else if (zeroCnt != ZERO_MAX) zeroD = zeroCnt + 1'b1;
    end

    readyD = (stateD inside {WAIT_RJ, READ_RJ, WAIT_COEFF, READ_COEFF, WAIT_DATA, SLEEPING});
  end

  assign bus.readyForData = readyQ;
  assign bus.memWrData    = memWrDataQ;
  assign bus.rjWrEn       = rjWrEnQ;
  assign bus.rjAddr       = rjAddrQ;
  assign bus.coeffWrEn    = coeffWrEnQ;
  assign bus.coeffAddr    = coeffAddrQ;
  assign bus.dataWrEn     = dataWrEnQ;
  assign bus.dataAddr     = dataAddrQ;
  assign bus.computeStart = startQ;
  assign bus.computeAbort = abortQ;
  assign bus.status       = state;

endmodule

// File: tb/tb_msdap_ctrl.sv
// tb_msdap_ctrl: self-checking bench for msdap_ctrl.
// Expected memory writes are queued by a transaction-level model and matched against every
// strobe the DUT raises; status and handshake are checked at the points the model predicts.
module tb_msdap_ctrl;
  localparam int DEPTH = 256;
  localparam int ZL    = 800;

  logic clk = 1'b0;
  logic resetN;
  logic softReset;
  always #5 clk = ~clk;

  msdap_ctrl_if #(.DATA_W(16), .RJ_AW(4), .COEFF_AW(9), .DATA_AW(8)) bus ();

  msdap_ctrl #(
    .DATA_W(16), .RJ_COUNT(16), .COEFF_COUNT(512), .DATA_DEPTH(256), .ZERO_LIMIT(800)
  ) dut (
    .clk(clk), .reset(resetN), .softReset(softReset), .bus(bus)
  );

  typedef struct {
    int kind;   // 0 rj, 1 coeff, 2 data
    int addr;
    int data;
  } wr_t;

  wr_t expQ[$];
  int  nChecks = 0, nFail = 0;
  int  startsSeen = 0, startsExp = 0, abortsSeen = 0, abortsExp = 0;

  // Abstract model state
  int  lastAddr = 0;
  bit  firstSample = 1'b0;
  int  zeroRun = 0;
  bit  sleeping = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic void pushExp(input int kind, input int addr, input int data);
    wr_t e;
    e.kind = kind; e.addr = addr; e.data = data;
    expQ.push_back(e);
  endfunction

  function automatic void pushClear();
    for (int i = 0; i < DEPTH; i++) pushExp(2, i, 0);
    firstSample = 1'b1;
    zeroRun     = 0;
    sleeping    = 1'b0;
  endfunction

  task automatic observe(input int kind, input int addr, input int data);
    wr_t e;
    nChecks++;
    if (expQ.size() == 0) begin
      nFail++;
      $display("FAIL unexpectedWrite: got kind %0d addr %0d data 0x%0h, expected no write",
               kind, addr, data);
    end else begin
      e = expQ.pop_front();
      if (e.kind != kind || e.addr != addr || e.data != data) begin
        nFail++;
        $display("FAIL write: got kind %0d addr %0d data 0x%0h, expected kind %0d addr %0d data 0x%0h",
                 kind, addr, data, e.kind, e.addr, e.data);
      end
    end
  endtask

  // Compare process: every strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (bus.rjWrEn)       observe(0, int'(bus.rjAddr),    int'(bus.memWrData));
    if (bus.coeffWrEn)    observe(1, int'(bus.coeffAddr), int'(bus.memWrData));
    if (bus.dataWrEn)     observe(2, int'(bus.dataAddr),  int'(bus.memWrData));
    if (bus.computeStart) startsSeen++;
    if (bus.computeAbort) abortsSeen++;
  end

  task automatic waitStatus(input int s, input int maxCyc, input string name);
    int n = 0;
    while (int'(bus.status) != s && n < maxCyc) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(bus.status), s);
  endtask

  task automatic sendLoad(input int kind, input int idx, input int data);
    @(negedge clk);
    check("loadReady", int'(bus.readyForData), 1);
    bus.inData    = 16'(data);
    bus.validData = 1'b1;
    pushExp(kind, idx, data);
    @(posedge clk);
  endtask

  task automatic sendSample(input int data, input bit junk);
    int t = 0;
    @(negedge clk);
    while (!bus.readyForData && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("sampleReady", int'(bus.readyForData), 1);
    bus.inData    = 16'(data);
    bus.validData = 1'b1;
    @(posedge clk);
    if (sleeping && data == 0) begin
      @(negedge clk);
      bus.validData = 1'b0;
      check("sleepNoStart", int'(bus.computeStart), 0);
      check("sleepStatus", int'(bus.status), 8);
    end else begin
      lastAddr    = firstSample ? 0 : (lastAddr + 1) % DEPTH;
      firstSample = 1'b0;
      pushExp(2, lastAddr, data);
      startsExp++;
      zeroRun = (data == 0) ? ((zeroRun < ZL) ? zeroRun + 1 : ZL) : 0;
      @(negedge clk);
      check("computeStart", int'(bus.computeStart), 1);
      if (junk) begin
        bus.validData = 1'b1;
        bus.inData    = 16'($urandom);
      end else begin
        bus.validData = 1'b0;
      end
      @(negedge clk);
      check("busyStatus", int'(bus.status), 6);
      bus.validData   = 1'b0;
      bus.computeDone = 1'b1;
      @(negedge clk);
      bus.computeDone = 1'b0;
      sleeping = (zeroRun == ZL);
      check("doneStatus", int'(bus.status), sleeping ? 8 : 5);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN          = 1'b0;
    softReset       = 1'b0;
    bus.inData      = '0;
    bus.validData   = 1'b0;
    bus.computeDone = 1'b0;

    #12;
    check("rstStatus", int'(bus.status), 0);
    check("rstReady", int'(bus.readyForData), 0);
    check("rstDataWrEn", int'(bus.dataWrEn), 0);
    check("rstDataAddr", int'(bus.dataAddr), 0);
    check("rstStart", int'(bus.computeStart), 0);

    @(negedge clk);
    pushClear();
    resetN = 1'b1;
    waitStatus(1, 400, "initDone");
    check("initClearCount", expQ.size(), 0);

    // Partial load with random gaps, softReset ignored while loading, reset at coeff word 100
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.validData = 1'b0;
      end
      softReset = (i == 5);
      sendLoad(0, i, int'($urandom_range(0, 65535)));
    end
    softReset = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(negedge clk);
        bus.validData = 1'b0;
      end
      sendLoad(1, i, int'($urandom_range(0, 65535)));
    end
    @(negedge clk);
    bus.validData = 1'b0;
    #2 resetN = 1'b0;
    #1;
    check("midRstStatus", int'(bus.status), 0);
    check("midRstRj", int'(bus.rjWrEn), 0);
    check("midRstCoeff", int'(bus.coeffWrEn), 0);
    check("midRstData", int'(bus.dataWrEn), 0);
    check("midRstReady", int'(bus.readyForData), 0);
    check("midRstCoeffAddr", int'(bus.coeffAddr), 0);
    check("midRstPending", expQ.size(), 0);

    @(negedge clk);
    pushClear();
    resetN = 1'b1;
    waitStatus(1, 400, "reinitDone");
    check("reinitClearCount", expQ.size(), 0);

    // Full load, validData held high
    for (int i = 0; i < 16; i++)  sendLoad(0, i, int'($urandom_range(0, 65535)));
    for (int i = 0; i < 512; i++) sendLoad(1, i, int'($urandom_range(0, 65535)));
    @(negedge clk);
    bus.validData = 1'b0;
    waitStatus(5, 5, "loadDone");
    check("rjAddrHold", int'(bus.rjAddr), 15);
    check("coeffAddrHold", int'(bus.coeffAddr), 511);

    // Sample stream 0x0001..0x0102 wraps the circular buffer
    for (int i = 1; i <= 258; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      sendSample(i, bit'($urandom_range(0, 1)));
    end
    check("streamAddr", int'(bus.dataAddr), 1);

    // Zero run into sleep, dropped zeros, wake-up
    for (int i = 0; i < ZL; i++) sendSample(0, bit'($urandom_range(0, 1)));
    check("sleepEntered", int'(bus.status), 8);
    for (int i = 0; i < 50; i++) sendSample(0, 1'b0);
    check("sleepAddrHeld", int'(bus.dataAddr), 33);
    check("sleepStarts", startsSeen, startsExp);
    sendSample(7, 1'b1);
    check("wakeAddr", int'(bus.dataAddr), 34);

    // softReset together with computeDone while WORKING
    @(negedge clk);
    bus.inData    = 16'h1234;
    bus.validData = 1'b1;
    @(posedge clk);
    lastAddr = (lastAddr + 1) % DEPTH;
    pushExp(2, lastAddr, 'h1234);
    startsExp++;
    @(negedge clk);
    bus.validData = 1'b0;
    check("abortStart", int'(bus.computeStart), 1);
    @(negedge clk);
    check("abortBusy", int'(bus.status), 6);
    softReset       = 1'b1;
    bus.computeDone = 1'b1;
    pushClear();
    @(negedge clk);
    abortsExp++;
    check("abortPulse", int'(bus.computeAbort), 1);
    check("abortStatus", int'(bus.status), 7);
    softReset       = 1'b0;
    bus.computeDone = 1'b0;
    waitStatus(5, 300, "clearDone");
    check("clearCount", expQ.size(), 0);
    sendSample(int'($urandom_range(1, 65535)), 1'b0);
    check("postClearAddr", int'(bus.dataAddr), 0);
    check("postClearRj", int'(bus.rjAddr), 15);
    check("postClearCoeff", int'(bus.coeffAddr), 511);

    // softReset wins over a word offered in WAIT_DATA
    @(negedge clk);
    softReset     = 1'b1;
    bus.validData = 1'b1;
    bus.inData    = 16'h0055;
    pushClear();
    @(negedge clk);
    check("srWaitStatus", int'(bus.status), 7);
    check("srWaitReady", int'(bus.readyForData), 0);
    softReset     = 1'b0;
    bus.validData = 1'b0;
    waitStatus(5, 300, "clear2Done");
    sendSample('h99, 1'b0);
    check("postClear2Addr", int'(bus.dataAddr), 0);

    repeat (3) @(negedge clk);
    check("pendingWrites", expQ.size(), 0);
    check("startCount", startsSeen, startsExp);
    check("abortCount", abortsSeen, abortsExp);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
